// File: rtl/hex_display_scanner.sv
// Multiplexed scan controller for an N-digit common-anode 7-seg display.
// New values are buffered and swapped in only on a frame boundary.
module hex_display_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 16,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  output logic [3:0]            o_hex,
  output logic [N_DIGITS-1:0]   o_digit_en_n,
  output logic                  o_dp_n,
  output logic                  o_frame_end
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(N_DIGITS - 1);

  logic [PW-1:0]       p;
  logic [DW-1:0]       d;
  logic [VW-1:0]       disp_val;
  logic [N_DIGITS-1:0] disp_dp;
  logic [VW-1:0]       pend_val;
  logic [N_DIGITS-1:0] pend_dp;
  logic                pend_vld;

  logic                p_last;
  logic                frame_end;
  logic                accept;
  logic                shown;
  logic                run_zero;
  logic [3:0]          nib [N_DIGITS];
  logic [N_DIGITS-1:0] zero_above;
  logic [N_DIGITS-1:0] supp;

  assign p_last    = (p == P_LAST);
  assign frame_end = p_last & (d == D_LAST);
  assign accept    = i_valid & ~pend_vld;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      p        <= '0;
      d        <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else begin
      p <= p_last ? '0 : p + PW'(1);
      if (p_last)
        d <= (d == D_LAST) ? '0 : d + DW'(1);
      // swap and accept are exclusive: one needs pend_vld, the other not
      if (frame_end && pend_vld) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_val <= i_value;
        pend_dp  <= i_dp;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++)
      nib[k] = disp_val[4*k +: 4];
  end

  // zero_above[k]: nibbles k..N_DIGITS-1 are all zero
  always_comb begin
    zero_above = '0;
    run_zero   = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run_zero      = run_zero & (nib[k] == 4'h0);
      zero_above[k] = run_zero;
    end
  end

  always_comb begin
    supp = '0;
    if (LZ_SUPPRESS != 0) begin
      for (int k = 1; k < N_DIGITS; k++)
        supp[k] = zero_above[k] & ~disp_dp[k];
    end
  end

  assign shown        = (p >= P_GUARD) & ~supp[d];
  assign o_ready      = ~pend_vld;
  assign o_hex        = nib[d];
  assign o_frame_end  = frame_end;
  assign o_dp_n       = shown ? ~disp_dp[d] : 1'b1;
  assign o_digit_en_n = shown ? ~(N_DIGITS'(1) << d) : '1;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (N=4, DIV=8, GUARD=2),
// one instance without and one with leading-zero suppression.
module tb_hex_display_scanner;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
  } ent_t;

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_value;
  logic [3:0]  i_dp;

  logic       rdy0, dpn0, fe0;
  logic [3:0] hex0, en0;
  logic       rdy1, dpn1, fe1;
  logic [3:0] hex1, en1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ent_t        sb[$];
  logic [15:0] m_val  = '0;
  logic [3:0]  m_dp   = '0;
  bit          m_pend = 0;

  hex_display_scanner #(
    .N_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .LZ_SUPPRESS(0)
  ) u0 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .o_ready(rdy0), .i_value(i_value), .i_dp(i_dp),
    .o_hex(hex0), .o_digit_en_n(en0), .o_dp_n(dpn0),
    .o_frame_end(fe0)
  );

  hex_display_scanner #(
    .N_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .LZ_SUPPRESS(1)
  ) u1 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .o_ready(rdy1), .i_value(i_value), .i_dp(i_dp),
    .o_hex(hex1), .o_digit_en_n(en1), .o_dp_n(dpn1),
    .o_frame_end(fe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {hex, en_n, dp_n, ready} for cycle c from the model display
  function automatic logic [9:0] exp_vec(bit lz, int c);
    int          p;
    int          d;
    logic [15:0] v;
    logic [15:0] hi;
    logic [3:0]  h;
    logic [3:0]  en;
    logic        dpn;
    bit          sup;
    bit          sh;
    p   = c % 8;
    d   = (c / 8) % 4;
    v   = m_val;
    h   = v[d*4 +: 4];
    hi  = v >> (4 * d);
    sup = lz && (d > 0) && (hi == 16'h0) && !m_dp[d];
    sh  = (p >= 2) && !sup;
    en  = sh ? ~(4'b0001 << d) : 4'hf;
    dpn = sh ? ~m_dp[d] : 1'b1;
    return {h, en, dpn, ~m_pend};
  endfunction

  task automatic tick();
    ent_t e;
    if (i_rst_n && (cyc % 32) == 31 && m_pend) begin
      e      = sb.pop_front();
      m_val  = e.v;
      m_dp   = e.dp;
      m_pend = 0;
    end else if (i_rst_n && i_valid && !m_pend) begin
      sb.push_back(ent_t'({i_value, i_dp}));
      m_pend = 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    cyc     = 0;
    m_pend  = 0;
    m_val   = '0;
    m_dp    = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    i_valid = 1'b0;
    i_value = '0;
    i_dp    = '0;
    i_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({rdy0, hex0, en0, dpn0, fe0} !== {1'b1, 4'h0, 4'hf, 2'b10}) begin
        n_fail++;
        $display("FAIL reset0 got=%h exp=%h",
                 {rdy0, hex0, en0, dpn0, fe0}, {1'b1, 4'h0, 4'hf, 2'b10});
      end
      n_tests++;
      if ({rdy1, hex1, en1, dpn1, fe1} !== {1'b1, 4'h0, 4'hf, 2'b10}) begin
        n_fail++;
        $display("FAIL reset1 got=%h exp=%h",
                 {rdy1, hex1, en1, dpn1, fe1}, {1'b1, 4'h0, 4'hf, 2'b10});
      end
    end
    i_rst_n = 1'b1;
    cyc     = 0;
    for (int i = 0; i < 96; i++) begin
      n_tests++;
      if ({fe0, fe1, rdy0} !== {{2{(cyc % 32) == 31}}, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_frame c=%0d got=%b exp=%b", cyc,
                 {fe0, fe1, rdy0}, {{2{(cyc % 32) == 31}}, 1'b1});
      end
      tick();
    end
  endtask

  task automatic test_load_scan();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      n_tests++;
      if ({hex0, en0, dpn0, rdy0} !== exp_vec(0, cyc)) begin
        n_fail++;
        $display("FAIL scan c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0}, exp_vec(0, cyc));
      end
      if (cyc == 10 || cyc == 32) begin
        n_tests++;
        if (rdy0 !== (cyc == 32)) begin
          n_fail++;
          $display("FAIL scan_ready c=%0d got=%b exp=%b", cyc, rdy0, cyc == 32);
        end
      end
      if (cyc == 33 || cyc == 36 || cyc == 44 || cyc == 52 || cyc == 60) begin
        logic [8:0] ex;
        case (cyc)
          33:      ex = {4'hf, 4'hF, 1'b1};
          36:      ex = {4'b1110, 4'hF, 1'b1};
          44:      ex = {4'b1101, 4'h2, 1'b1};
          52:      ex = {4'b1011, 4'hA, 1'b0};
          default: ex = {4'b0111, 4'h1, 1'b1};
        endcase
        n_tests++;
        if ({en0, hex0, dpn0} !== ex) begin
          n_fail++;
          $display("FAIL scan_digit c=%0d got=%h exp=%h", cyc,
                   {en0, hex0, dpn0}, ex);
        end
      end
      i_valid = (cyc == 3);
      i_value = 16'h1A2F;
      i_dp    = 4'b0100;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 72; i++) begin
      n_tests++;
      if ({hex0, en0, dpn0, rdy0} !== exp_vec(0, cyc)) begin
        n_fail++;
        $display("FAIL b2b c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0}, exp_vec(0, cyc));
      end
      if (cyc == 33 || cyc == 63 || cyc == 64) begin
        n_tests++;
        if (rdy0 !== (cyc == 64)) begin
          n_fail++;
          $display("FAIL b2b_ready c=%0d got=%b exp=%b", cyc, rdy0, cyc == 64);
        end
      end
      if (cyc == 40 || cyc == 66) begin
        n_tests++;
        if (hex0 !== ((cyc == 40) ? 4'h1 : 4'h2)) begin
          n_fail++;
          $display("FAIL b2b_hex c=%0d got=%h exp=%h", cyc, hex0,
                   (cyc == 40) ? 4'h1 : 4'h2);
        end
      end
      i_valid = (cyc >= 3 && cyc <= 32);
      i_value = (cyc == 3) ? 16'h1111 : 16'h2222;
      i_dp    = 4'b0000;
      tick();
    end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      n_tests++;
      if ({hex0, en0, dpn0, rdy0} !== exp_vec(0, cyc)) begin
        n_fail++;
        $display("FAIL bnd c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0}, exp_vec(0, cyc));
      end
      if (cyc == 32 || cyc == 64) begin
        n_tests++;
        if (rdy0 !== (cyc == 64)) begin
          n_fail++;
          $display("FAIL bnd_ready c=%0d got=%b exp=%b", cyc, rdy0, cyc == 64);
        end
      end
      if (cyc == 42 || cyc == 74) begin
        n_tests++;
        if ({en0, hex0} !== {4'b1101, (cyc == 74) ? 4'hC : 4'h0}) begin
          n_fail++;
          $display("FAIL bnd_digit c=%0d got=%h exp=%h", cyc, {en0, hex0},
                   {4'b1101, (cyc == 74) ? 4'hC : 4'h0});
        end
      end
      i_valid = (cyc == 31);
      i_value = 16'h00C0;
      i_dp    = 4'b0000;
      tick();
    end
  endtask

  task automatic test_lz();
    do_reset();
    for (int i = 0; i < 128; i++) begin
      n_tests++;
      if ({hex1, en1, dpn1, rdy1} !== exp_vec(1, cyc)) begin
        n_fail++;
        $display("FAIL lz c=%0d got=%h exp=%h", cyc,
                 {hex1, en1, dpn1, rdy1}, exp_vec(1, cyc));
      end
      n_tests++;
      if ({hex0, en0, dpn0, rdy0} !== exp_vec(0, cyc)) begin
        n_fail++;
        $display("FAIL lz_off c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0}, exp_vec(0, cyc));
      end
      if (cyc == 34 || cyc == 42 || cyc == 50 || cyc == 58 ||
          cyc == 66 || cyc == 74 || cyc == 114 || cyc == 122) begin
        logic [4:0] ex;
        case (cyc)
          34:      ex = {4'b1110, 1'b1};
          42:      ex = {4'b1101, 1'b1};
          66:      ex = {4'b1110, 1'b1};
          122:     ex = {4'b0111, 1'b0};
          default: ex = {4'b1111, 1'b1};
        endcase
        n_tests++;
        if ({en1, dpn1} !== ex) begin
          n_fail++;
          $display("FAIL lz_digit c=%0d got=%b exp=%b", cyc, {en1, dpn1}, ex);
        end
      end
      if (cyc == 42) begin
        n_tests++;
        if (hex1 !== 4'h5) begin
          n_fail++;
          $display("FAIL lz_hex c=%0d got=%h exp=5", cyc, hex1);
        end
      end
      i_valid = (cyc == 3 || cyc == 35 || cyc == 67);
      i_value = (cyc == 3) ? 16'h0050 : 16'h0000;
      i_dp    = (cyc == 67) ? 4'b1000 : 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      n_tests++;
      if ({hex0, en0, dpn0, rdy0} !== exp_vec(0, cyc)) begin
        n_fail++;
        $display("FAIL mid c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0}, exp_vec(0, cyc));
      end
      i_valid = (cyc == 3 || cyc == 40);
      i_value = (cyc == 3) ? 16'h1234 : 16'h5678;
      i_dp    = (cyc == 3) ? 4'b0000 : 4'b0001;
      tick();
    end
    n_tests++;
    if ({en0, hex0, rdy0} !== {4'b1101, 4'h3, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_pre got=%h exp=%h", {en0, hex0, rdy0},
               {4'b1101, 4'h3, 1'b0});
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({en0, hex0, rdy0, dpn0, en1} !== {4'hf, 4'h0, 2'b11, 4'hf}) begin
      n_fail++;
      $display("FAIL mid_rst got=%h exp=%h", {en0, hex0, rdy0, dpn0, en1},
               {4'hf, 4'h0, 2'b11, 4'hf});
    end
    i_rst_n = 1'b1;
    cyc     = 0;
    m_pend  = 0;
    m_val   = '0;
    m_dp    = '0;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      n_tests++;
      if ({hex0, en0, dpn0, rdy0, fe0} !==
          {exp_vec(0, cyc), (cyc % 32) == 31}) begin
        n_fail++;
        $display("FAIL mid_after c=%0d got=%h exp=%h", cyc,
                 {hex0, en0, dpn0, rdy0, fe0},
                 {exp_vec(0, cyc), (cyc % 32) == 31});
      end
      tick();
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_value = '0;
    i_dp    = '0;
    test_reset();
    test_load_scan();
    test_back_to_back();
    test_boundary();
    test_lz();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Accepts a packed hex value and decimal-point mask over a valid/ready handshake and holds it in a pending buffer.
- Swaps that buffer into the display registers only at a frame boundary, so a display never shows a mix of old and new digits.
- Each cycle it presents one 4-bit nibble on o_hex, which feeds the downstream hex-to-7-segment decoder, and drives the matching active-low digit enable.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..16); digit N_DIGITS-1 is most significant.
- REFRESH_DIV, 1000, clock cycles per digit slot; must be at least GUARD_CYCLES+2.
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV-1.
- LZ_SUPPRESS, 0, when 1, leading zero digits are blanked.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, synchronous active-low reset.
- i_valid, input, 1, new display data offered.
- o_ready, output, 1, pending buffer empty; data can be accepted.
- i_value, input, 4*N_DIGITS, packed nibbles; nibble k is [4k+3:4k].
- i_dp, input, N_DIGITS, decimal-point enables, 1 = lit.
- o_hex, output, 4, nibble of the current digit, to the decoder.
- o_digit_en_n, output, N_DIGITS, active-low anode enables.
- o_dp_n, output, 1, active-low decimal-point segment.
- o_frame_end, output, 1, one-cycle pulse on the frame's last cycle.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous and active-low. All state updates on the rising edge of i_clk.
- State:
  - prescaler p, 0..REFRESH_DIV-1.
  - digit index d, 0..N_DIGITS-1.
  - display registers disp_val and disp_dp.
  - pending registers pend_val and pend_dp, plus flag pend_vld.
- Reset values: p=0, d=0, disp_val=0, disp_dp=0, pend_vld=0. Reset wins over every other event, including an accept or a frame boundary in the same cycle.
- Output values while reset is asserted:
  - o_ready=1, o_hex=0, o_digit_en_n all ones, o_dp_n=1, o_frame_end=0.
  - These are the values the output equations give for the reset state.
- Output timing: all outputs are combinational functions of registered state only. There is no combinational path from i_valid, i_value or i_dp to any output.
- Counting:
  - p increments every cycle. At p=REFRESH_DIV-1, p wraps to 0 and d advances.
  - d wraps from N_DIGITS-1 to 0.
  - One frame lasts N_DIGITS*REFRESH_DIV cycles.
- Frame boundary: the cycle with d=N_DIGITS-1 and p=REFRESH_DIV-1. On that cycle:
  - o_frame_end=1.
  - If pend_vld=1: disp_val and disp_dp take the pending values on the closing edge, and pend_vld clears.
- Handshake:
  - o_ready = ~pend_vld.
  - Transfer happens when i_valid & o_ready. On transfer, i_value and i_dp are captured into the pending registers and pend_vld is set.
  - A transfer on a frame-boundary cycle fills the pending buffer only. It is applied at the next boundary, never at the current one.
  - While pend_vld=1, i_valid is ignored; the sender must hold its data.
  - i_valid does not need to stay high once the transfer has happened.
- Digit output:
  - o_hex = disp_val nibble d, in every cycle including guard and blanked slots.
  - Digit d is shown when p >= GUARD_CYCLES and d is not suppressed. Its anode bit in o_digit_en_n is then low, and every other bit is high.
  - Otherwise o_digit_en_n is all ones.
  - o_dp_n = ~disp_dp[d] while digit d is shown, else 1.
- Leading-zero suppression (LZ_SUPPRESS=1 only):
  - Digit d (d>0) is suppressed when nibbles d..N_DIGITS-1 of disp_val are all zero.
  - Suppression is decided from disp_val, not pend_val.
  - Digit 0 is never suppressed.
  - disp_dp[d]=1 overrides suppression of digit d.
- Arithmetic: counter widths are $clog2 of their ranges, with a minimum of 1 bit. No counter may exceed its range.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, LZ_SUPPRESS=0 unless stated. Cycle 0 is the first cycle after reset release.
1. Reset and idle:
   - Stimulus: hold i_rst_n=0 for 3 cycles, then release.
   - Response: during reset, o_digit_en_n=4'b1111, o_dp_n=1, o_ready=1, o_frame_end=0, o_hex=0. After release, o_frame_end pulses at cycles 31, 63, 95.
2. Load and scan:
   - Stimulus: i_value=16'h1A2F, i_dp=4'b0100, i_valid=1 at cycle 3 only.
   - Response:
     - o_ready is 0 on cycles 4..31 and 1 again from cycle 32.
     - Cycles 32..33: o_digit_en_n=1111, o_hex=F.
     - Cycles 34..39: o_digit_en_n=1110, o_hex=F.
     - Cycles 42..47: o_digit_en_n=1101, o_hex=2.
     - Cycles 50..55: o_digit_en_n=1011, o_hex=A, o_dp_n=0.
     - Cycles 58..63: o_digit_en_n=0111, o_hex=1.
3. Back-pressure:
   - Stimulus: offer 16'h1111 at cycle 3, then hold i_valid=1 with 16'h2222 from cycle 4.
   - Response: 16'h2222 is accepted at cycle 32, o_ready=0 on 33..63, and 2222 is displayed from cycle 64.
4. Accept on boundary:
   - Stimulus: a single i_valid pulse at cycle 31 with 16'h00C0.
   - Response: display still shows 0000 during cycles 32..63; 00C0 is displayed from cycle 64.
5. Leading-zero suppression (LZ_SUPPRESS=1):
   - Stimulus: load 16'h0050.
   - Response: digits 3 and 2 keep anodes high for the whole slot; digits 1 (hex 5) and 0 (hex 0) are shown.
   - Stimulus: load 16'h0000.
   - Response: only digit 0 is enabled.
   - Stimulus: load 16'h0000 with i_dp=4'b1000.
   - Response: digit 3 is shown with o_dp_n=0.
6. Reset mid-operation:
   - Stimulus: assert i_rst_n=0 at cycle 45, with pending data present and digit 1 active.
   - Response: next cycle, o_digit_en_n=1111, o_ready=1, and the display reads 0000. After release, the frame restarts with the first boundary 32 cycles later.
